// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 move datapath: cell/grid types,
// direction and sequencer-state encodings, and pass-count limits.
package game_pkg;

    typedef logic [3:0] cell_t;
    typedef cell_t [0:3][0:3] grid_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int WIN_TILE   = 11;
    localparam int MERGE_PASS = 4;
    localparam int LAST_PASS  = 7;
    localparam int COUNT_W    = $clog2(LAST_PASS + 1);
    localparam int SCORE_W    = 20;

endpackage

// File: rtl/grid_status.sv
// Combinational board status: equality of two grids and presence of a
// winning tile in the first grid.
module grid_status
    import game_pkg::*;
(
    input  grid_t grid_a_i,
    input  grid_t grid_b_i,
    output logic  equal_o,
    output logic  win_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        win_o   = 1'b0;
        equal_o = (grid_a_i == grid_b_i);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (grid_a_i[r][c] >= cell_t'(WIN_TILE)) begin
                    win_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Owns the 2048 board register and steps one move through the external
// direction stages. Optional score output is enabled by MOVE_SCORE_EN.
module move_sequencer
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           dir,
    input  logic                 load_en,
    input  grid_t                grid_in,
    input  logic                 spawn_en,
    input  logic [1:0]           spawn_row,
    input  logic [1:0]           spawn_col,
    input  cell_t                spawn_val,
    input  grid_t                grid_up,
    input  grid_t                grid_down,
    input  grid_t                grid_left,
    input  grid_t                grid_right,
    output int                   count,
    output grid_t                grid_q,
    output logic                 busy,
    output logic                 done,
    output logic                 moved,
`ifdef MOVE_SCORE_EN
    output logic [SCORE_W-1:0]   score,
`endif
    output logic                 win
);

    state_t              state_q;
    dir_t                dir_q;
    grid_t               board_q;
    grid_t               snap_q;
    logic [COUNT_W-1:0]  count_q;
    logic                busy_q;
    logic                done_q;
    logic                moved_q;
    grid_t               sel_grid;
    logic                same_as_snap;

    always_comb begin
        sel_grid = grid_up;
        case (dir_q)
            DIR_UP:    sel_grid = grid_up;
            DIR_DOWN:  sel_grid = grid_down;
            DIR_LEFT:  sel_grid = grid_left;
            DIR_RIGHT: sel_grid = grid_right;
            default:   sel_grid = grid_up;
        endcase
    end

    grid_status u_status (
        .grid_a_i (board_q),
        .grid_b_i (snap_q),
        .equal_o  (same_as_snap),
        .win_o    (win)
    );

`ifdef MOVE_SCORE_EN
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_inc;

    // A cell that grew by exactly one exponent during the merge pass is a merge.
    always_comb begin
        score_inc = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_q[r][c] != '0 &&
                    sel_grid[r][c] == cell_t'(board_q[r][c] + cell_t'(1))) begin
                    score_inc = score_inc + (SCORE_W'(1) << sel_grid[r][c]);
                end
            end
        end
    end

    assign score = score_q;
`endif

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            board_q <= '0;
            snap_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            moved_q <= 1'b0;
`ifdef MOVE_SCORE_EN
            score_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_en) begin
                        board_q <= grid_in;
                        moved_q <= 1'b0;
`ifdef MOVE_SCORE_EN
                        score_q <= '0;
`endif
                    end else if (spawn_en) begin
                        board_q[spawn_row][spawn_col] <= spawn_val;
                    end else if (start) begin
                        dir_q   <= dir_t'(dir);
                        snap_q  <= board_q;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    board_q <= sel_grid;
`ifdef MOVE_SCORE_EN
                    if (count_q == COUNT_W'(MERGE_PASS)) begin
                        score_q <= score_q + score_inc;
                    end
`endif
                    if (count_q == COUNT_W'(LAST_PASS)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        count_q <= count_q + COUNT_W'(1);
                    end
                end
                ST_DONE: begin
                    moved_q <= !same_as_snap;
                    count_q <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign count  = int'(count_q);
    assign grid_q = board_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign moved  = moved_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: the bench supplies reference
// direction stages and a scoreboard of expected move results.
module tb_move_sequencer;
    import game_pkg::*;

    typedef cell_t [0:3] line_t;
    typedef struct {
        grid_t       grid;
        logic        moved;
        logic [19:0] score;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  dir = 2'd0;
    logic        load_en = 1'b0;
    grid_t       grid_in = '0;
    logic        spawn_en = 1'b0;
    logic [1:0]  spawn_row = 2'd0;
    logic [1:0]  spawn_col = 2'd0;
    cell_t       spawn_val = 4'd0;
    grid_t       grid_up, grid_down, grid_left, grid_right;
    int          count;
    grid_t       grid_q;
    logic        busy, done, moved, win;
`ifdef MOVE_SCORE_EN
    logic [19:0] score;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    grid_t       model = '0;
    logic [19:0] model_score = '0;

    always #5 clk = ~clk;

    move_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dir        (dir),
        .load_en    (load_en),
        .grid_in    (grid_in),
        .spawn_en   (spawn_en),
        .spawn_row  (spawn_row),
        .spawn_col  (spawn_col),
        .spawn_val  (spawn_val),
        .grid_up    (grid_up),
        .grid_down  (grid_down),
        .grid_left  (grid_left),
        .grid_right (grid_right),
        .count      (count),
        .grid_q     (grid_q),
        .busy       (busy),
        .done       (done),
        .moved      (moved),
`ifdef MOVE_SCORE_EN
        .score      (score),
`endif
        .win        (win)
    );

    // Reference stages: lane i=0 is the edge tiles move toward.
    function automatic void cell_pos(input dir_t d, input int lane, input int i,
                                     output int r, output int c);
        case (d)
            DIR_UP:    begin r = i;     c = lane;  end
            DIR_DOWN:  begin r = 3 - i; c = lane;  end
            DIR_LEFT:  begin r = lane;  c = i;     end
            default:   begin r = lane;  c = 3 - i; end
        endcase
    endfunction

    function automatic line_t compact_line(input line_t l);
        for (int i = 0; i < 3; i++) begin
            if (l[i] == 4'd0) begin
                l[i]     = l[i+1];
                l[i+1]   = 4'd0;
            end
        end
        return l;
    endfunction

    function automatic line_t merge_line(input line_t l, output logic [19:0] add);
        int i = 0;
        add = '0;
        while (i < 3) begin
            if (l[i] != 4'd0 && l[i] == l[i+1]) begin
                l[i]   = l[i] + 4'd1;
                l[i+1] = 4'd0;
                add    = add + (20'd1 << l[i]);
                i      = i + 2;
            end else begin
                i = i + 1;
            end
        end
        return l;
    endfunction

    function automatic grid_t apply_pass(input grid_t g, input dir_t d, input int pass,
                                         output logic [19:0] add);
        grid_t       o = g;
        line_t       l;
        logic [19:0] a;
        int          r, c;
        add = '0;
        for (int lane = 0; lane < 4; lane++) begin
            for (int i = 0; i < 4; i++) begin
                cell_pos(d, lane, i, r, c);
                l[i] = g[r][c];
            end
            if (pass == MERGE_PASS) begin
                l   = merge_line(l, a);
                add = add + a;
            end else begin
                l = compact_line(l);
            end
            for (int i = 0; i < 4; i++) begin
                cell_pos(d, lane, i, r, c);
                o[r][c] = l[i];
            end
        end
        return o;
    endfunction

    function automatic grid_t stage(input grid_t g, input dir_t d, input int pass);
        logic [19:0] unused_add;
        return apply_pass(g, d, pass, unused_add);
    endfunction

    always_comb begin
        grid_up    = stage(grid_q, DIR_UP,    count);
        grid_down  = stage(grid_q, DIR_DOWN,  count);
        grid_left  = stage(grid_q, DIR_LEFT,  count);
        grid_right = stage(grid_q, DIR_RIGHT, count);
    end

    task automatic do_load(input grid_t g);
        @(negedge clk);
        load_en = 1'b1;
        grid_in = g;
        @(negedge clk);
        load_en = 1'b0;
        model = g;
        model_score = '0;
    endtask

    // Starts a move at the current IDLE negedge and follows it to IDLE again.
    task automatic run_move(input dir_t d);
        exp_t        e;
        exp_t        got;
        logic [19:0] add;
        e.grid  = model;
        e.score = model_score;
        for (int p = 0; p <= LAST_PASS; p++) begin
            e.grid  = apply_pass(e.grid, d, p, add);
            e.score = e.score + add;
        end
        e.moved = (e.grid != model);
        model = e.grid;
        model_score = e.score;
        sb.push_back(e);

        start = 1'b1;
        dir = d;
        @(negedge clk);
        start = 1'b0;
        dir = ~d;
        for (int k = 0; k <= LAST_PASS; k++) begin
            n_checks++;
            if (busy !== 1'b1 || count !== k) begin
                n_fail++;
                $display("FAIL run_pass%0d: busy=%b count=%0d, want busy=1 count=%0d", k, busy, count, k);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_latency: done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, want 1");
        end else begin
            got = sb.pop_front();
            if (grid_q !== got.grid) begin
                n_fail++;
                $display("FAIL move_grid: got %h, want %h", grid_q, got.grid);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || moved !== got.moved) begin
                n_fail++;
                $display("FAIL moved_flag: done=%b moved=%b, want done=0 moved=%b", done, moved, got.moved);
            end
`ifdef MOVE_SCORE_EN
            n_checks++;
            if (score !== got.score) begin
                n_fail++;
                $display("FAIL move_score: got %0d, want %0d", score, got.score);
            end
`endif
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (grid_q !== '0 || count !== 0 || busy !== 1'b0 || done !== 1'b0 ||
            moved !== 1'b0 || win !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: grid=%h count=%0d busy=%b done=%b moved=%b win=%b, want all 0",
                     grid_q, count, busy, done, moved, win);
        end
`ifdef MOVE_SCORE_EN
        n_checks++;
        if (score !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_score: got %0d, want 0", score);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        grid_t g = 64'h1120_0000_0000_0000;
        do_load(g);
        n_checks++;
        if (grid_q !== g || busy !== 1'b0 || win !== 1'b0) begin
            n_fail++;
            $display("FAIL load: grid=%h busy=%b win=%b, want grid=%h busy=0 win=0", grid_q, busy, win, g);
        end
    endtask

    task automatic test_basic_move;
        logic [15:0] want_row0 = 16'h2200;
        run_move(DIR_LEFT);
        n_checks++;
        if (grid_q[0] !== want_row0 || moved !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_row0: row0=%h moved=%b, want row0=%h moved=1", grid_q[0], moved, want_row0);
        end
        do_load(64'h1000_1000_0200_0200);
        run_move(DIR_UP);
    endtask

    task automatic test_no_change;
        grid_t g = 64'h1230_4500_6000_0000;
        do_load(g);
        run_move(DIR_LEFT);
        n_checks++;
        if (grid_q !== g || moved !== 1'b0) begin
            n_fail++;
            $display("FAIL packed_board: grid=%h moved=%b, want grid=%h moved=0", grid_q, moved, g);
        end
    endtask

    task automatic test_priority;
        grid_t g = 64'h0000_0000_0000_0000;
        do_load(64'h0000_0000_0300_0000);
        @(negedge clk);
        spawn_en = 1'b1; start = 1'b1; spawn_row = 2'd2; spawn_col = 2'd1; spawn_val = 4'd5;
        @(negedge clk);
        spawn_en = 1'b0; start = 1'b0;
        n_checks++;
        if (grid_q[2][1] !== 4'd5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spawn_over_start: cell=%0d busy=%b, want cell=5 busy=0", grid_q[2][1], busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL spawn_stays_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        g = 64'h0400_0000_0000_0001;
        load_en = 1'b1; spawn_en = 1'b1; start = 1'b1; grid_in = g;
        spawn_row = 2'd0; spawn_col = 2'd0; spawn_val = 4'd7;
        @(negedge clk);
        load_en = 1'b0; spawn_en = 1'b0; start = 1'b0;
        model = g;
        model_score = '0;
        n_checks++;
        if (grid_q !== g || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_all: grid=%h busy=%b, want grid=%h busy=0", grid_q, busy, g);
        end
    endtask

    task automatic test_win_spawn;
        n_checks++;
        if (win !== 1'b0) begin
            n_fail++;
            $display("FAIL win_before_spawn: got %b, want 0", win);
        end
        spawn_en = 1'b1; spawn_row = 2'd1; spawn_col = 2'd2; spawn_val = 4'd11;
        @(negedge clk);
        spawn_en = 1'b0;
        model[1][2] = 4'd11;
        n_checks++;
        if (win !== 1'b1 || grid_q !== model) begin
            n_fail++;
            $display("FAIL win_after_spawn: win=%b grid=%h, want win=1 grid=%h", win, grid_q, model);
        end
    endtask

    task automatic test_back_to_back;
        do_load(64'h0000_0000_0000_2020);
        run_move(DIR_LEFT);
        run_move(DIR_RIGHT);
    endtask

    task automatic test_reset_mid_run;
        int cyc = 0;
        do_load(64'h1111_2222_0000_0000);
        start = 1'b1; dir = DIR_RIGHT;
        @(negedge clk);
        start = 1'b0;
        while (count != 3 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (count !== 3) begin
            n_fail++;
            $display("FAIL reach_pass3: count=%0d, want 3", count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (grid_q !== '0 || count !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_abort: grid=%h count=%0d busy=%b, want 0 0 0", grid_q, count, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model = '0;
        model_score = '0;
    endtask

`ifdef MOVE_SCORE_EN
    task automatic test_score;
        do_load(64'h1133_0000_0000_0000);
        run_move(DIR_LEFT);
        n_checks++;
        if (score !== 20'd20) begin
            n_fail++;
            $display("FAIL score_merge: got %0d, want 20", score);
        end
        do_load(64'h0000_0000_0000_0000);
        n_checks++;
        if (score !== 20'd0) begin
            n_fail++;
            $display("FAIL score_clear: got %0d, want 0", score);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_basic_move();
        test_no_change();
        test_priority();
        test_win_spawn();
        test_back_to_back();
        test_reset_mid_run();
`ifdef MOVE_SCORE_EN
        test_score();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
